// File: rtl/hist_readout_if.sv
// Output stream of hist_readout: one histogram bin per accepted beat.
interface hist_readout_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_bin;
  logic [DW-1:0] out_count;
  logic          out_last;

  modport master (output out_valid, out_bin, out_count, out_last, input out_ready);
  modport slave  (input out_valid, out_bin, out_count, out_last, output out_ready);
endinterface

// File: rtl/hist_readout.sv
// Histogram RAM drain: sweeps all bins, streams counts with bin index and last flag,
// optionally zeroing each bin as its read data returns.
module hist_readout #(
  parameter int NBINS      = 32,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_rdaddr,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] ram_wraddr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  hist_readout_if.master stream
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] bin;
    logic [DW-1:0] count;
  } entry_t;

  state_t        state;
  logic          clear_q;
  logic [AW-1:0] ptr;
  logic [AW-1:0] rdaddr_q;

  logic [RD_LAT-1:0] sr_v;
  logic [AW-1:0]     sr_bin [RD_LAT];

  entry_t        fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic issue;
  logic push;
  logic pop;
  logic sweep_end;
  int   inflight;

  // NOTE: always_comb uses blocking assignments and gives every variable a
  // default first, so the accumulator never holds a value across evaluations.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(sr_v[i]);
  end

  // Credit: reads in flight plus buffered entries never exceed the FIFO size,
  // so every returning read has a slot waiting for it.
  assign issue     = (state == RUN) && ((inflight + int'(count)) < FIFO_DEPTH);
  assign push      = sr_v[RD_LAT-1];
  assign pop       = stream.out_valid && stream.out_ready;
  assign sweep_end = (inflight == 0) && ((count == '0) || ((count == CW'(1)) && pop));

  assign ram_rdaddr = issue ? ptr : rdaddr_q;
  assign ram_wren   = push && clear_q;
  assign ram_wraddr = sr_bin[RD_LAT-1];
  assign ram_data   = '0;

  assign stream.out_valid = (count != '0);
  assign {stream.out_last, stream.out_bin, stream.out_count} = fifo[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      clear_q  <= 1'b0;
      ptr      <= '0;
      rdaddr_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            clear_q <= clear_en;
            ptr     <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            ptr      <= ptr + AW'(1);
            rdaddr_q <= ptr;
            if (ptr == AW'(NBINS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (sweep_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tracker: one slot per RAM pipeline stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_v <= '0;
      for (int i = 0; i < RD_LAT; i++) sr_bin[i] <= '0;
    end else begin
      sr_v[0]   <= issue;
      sr_bin[0] <= ptr;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_bin[i] <= sr_bin[i-1];
      end
    end
  end

  // NOTE: the FIFO storage is reset on purpose; it is only a few entries and
  // the head drives the output payload, which must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr].last  <= (sr_bin[RD_LAT-1] == AW'(NBINS - 1));
        fifo[wr_ptr].bin   <= sr_bin[RD_LAT-1];
        fifo[wr_ptr].count <= ram_q;
        wr_ptr             <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_hist_readout.sv
// Self-checking bench for hist_readout: behavioural RAM, expected-stream queue, timing checks.
module tb_hist_readout;

  localparam int NBINS      = 32;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          clear_en = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_rdaddr;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;

  hist_readout_if #(.AW(AW), .DW(DW)) stream ();

  hist_readout #(
    .NBINS(NBINS), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .clear_en(clear_en),
    .busy(busy),
    .done(done),
    .ram_rdaddr(ram_rdaddr),
    .ram_q(ram_q),
    .ram_wraddr(ram_wraddr),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .stream(stream)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: two-cycle read latency, write port used for clears and preloads.
  logic [DW-1:0] mem [NBINS];
  logic [DW-1:0] load_val [NBINS];
  logic          load_req = 1'b0;
  logic [DW-1:0] q1;

  always @(posedge clk) begin
    q1    <= mem[ram_rdaddr];
    ram_q <= q1;
    if (load_req) begin
      for (int k = 0; k < NBINS; k++) mem[k] <= load_val[k];
    end else if (ram_wren) begin
      mem[ram_wraddr] <= '0;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc, issues, pops, wr_seen, n_done, first_valid, last_cyc, done_cyc;
  bit clear_mode = 1'b0;
  bit hold_prev = 1'b0;
  bit busy_prev = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] hold_bin;
  logic [DW-1:0] hold_cnt;
  logic          hold_last;
  int            exp_bin [$];
  logic [DW-1:0] exp_cnt [$];
  logic [DW-1:0] orig [NBINS];

  task automatic do_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int k = 0; k < NBINS; k++) orig[k] = load_val[k];
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 2 && c >= 12 && c < 32) return 1'b0;
    return logic'($urandom_range(0, 1));
  endfunction

  // Per-cycle scoreboard; called at the falling edge after the next ready is driven.
  task automatic observe();
    int            eb;
    logic [DW-1:0] ec;
    logic          pop_now;
    if (busy === 1'b1 && (!busy_prev || ram_rdaddr !== prev_addr)) begin
      checks++;
      if (ram_rdaddr !== AW'(issues)) begin
        failures++;
        $display("FAIL issue_order cyc=%0d: rdaddr=%0d expected=%0d", cyc, ram_rdaddr, issues);
      end
      issues++;
    end
    busy_prev = (busy === 1'b1);
    prev_addr = ram_rdaddr;
    if (busy === 1'b1) begin
      checks++;
      if (issues - pops > FIFO_DEPTH) begin
        failures++;
        $display("FAIL outstanding cyc=%0d: got=%0d limit=%0d", cyc, issues - pops, FIFO_DEPTH);
      end
    end
    if (ram_wren === 1'b1) begin
      checks++;
      if (!clear_mode || ram_wraddr !== AW'(wr_seen) || ram_data !== '0) begin
        failures++;
        $display("FAIL clear_write cyc=%0d: addr=%0d data=%h expected addr=%0d data=0 clear=%0d",
                 cyc, ram_wraddr, ram_data, wr_seen, clear_mode);
      end
      wr_seen++;
    end
    if (done === 1'b1) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL done_busy cyc=%0d: busy=%b expected=0", cyc, busy);
      end
    end
    if (hold_prev) begin
      checks++;
      if (stream.out_valid !== 1'b1 || stream.out_bin !== hold_bin ||
          stream.out_count !== hold_cnt || stream.out_last !== hold_last) begin
        failures++;
        $display("FAIL stall_stable cyc=%0d: v=%b bin=%0d cnt=%h expected v=1 bin=%0d cnt=%h",
                 cyc, stream.out_valid, stream.out_bin, stream.out_count, hold_bin, hold_cnt);
      end
    end
    if (stream.out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    pop_now = (stream.out_valid === 1'b1) && (stream.out_ready === 1'b1);
    if (pop_now) begin
      checks++;
      if (exp_bin.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry cyc=%0d: bin=%0d cnt=%h expected none",
                 cyc, stream.out_bin, stream.out_count);
      end else begin
        eb = exp_bin.pop_front();
        ec = exp_cnt.pop_front();
        if (stream.out_bin !== AW'(eb) || stream.out_count !== ec ||
            stream.out_last !== (eb == NBINS - 1)) begin
          failures++;
          $display("FAIL stream cyc=%0d: bin=%0d cnt=%h last=%b expected bin=%0d cnt=%h last=%b",
                   cyc, stream.out_bin, stream.out_count, stream.out_last, eb, ec, (eb == NBINS - 1));
        end
      end
      if (stream.out_last === 1'b1) last_cyc = cyc;
      pops++;
    end
    hold_prev = (stream.out_valid === 1'b1) && (stream.out_ready !== 1'b1);
    hold_bin  = stream.out_bin;
    hold_cnt  = stream.out_count;
    hold_last = stream.out_last;
  endtask

  task automatic tick(input logic rdy);
    @(negedge clk);
    cyc++;
    stream.out_ready = rdy;
    observe();
  endtask

  task automatic begin_sweep(input bit clr);
    exp_bin.delete();
    exp_cnt.delete();
    for (int k = 0; k < NBINS; k++) begin
      exp_bin.push_back(k);
      exp_cnt.push_back(mem[k]);
      orig[k] = mem[k];
    end
    issues = 0; pops = 0; wr_seen = 0; n_done = 0; clear_mode = clr;
    first_valid = -1; last_cyc = -1; done_cyc = -1; cyc = -1;
  endtask

  // Cycle 0 is the cycle with start high; returns at the falling edge of the done cycle.
  task automatic run_sweep(input bit clr, input int mode, input bit glitch);
    int bad;
    begin_sweep(clr);
    tick(ready_for(mode, 0));
    start = 1'b1;
    clear_en = clr;
    while (done_cyc < 0 && cyc < 1000) begin
      tick(ready_for(mode, cyc + 1));
      start    = glitch && (cyc == 5 || cyc == 6);
      clear_en = (glitch && (cyc == 5 || cyc == 6)) ? !clr : clr;
    end
    start = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL sweep_timeout: no done within %0d cycles", cyc);
    end
    checks++;
    if (exp_bin.size() != 0 || issues != NBINS) begin
      failures++;
      $display("FAIL stream_complete: missing=%0d issues=%0d expected missing=0 issues=%0d",
               exp_bin.size(), issues, NBINS);
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL done_count: got=%0d expected=1", n_done);
    end
    checks++;
    if (wr_seen != (clr ? NBINS : 0)) begin
      failures++;
      $display("FAIL clear_count: got=%0d expected=%0d", wr_seen, clr ? NBINS : 0);
    end
    bad = 0;
    for (int k = 0; k < NBINS; k++)
      if (mem[k] !== (clr ? {DW{1'b0}} : orig[k])) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ram_contents: wrong_bins=%0d expected=0", bad);
    end
  endtask

  task automatic check_timing(input string tag);
    checks++;
    if (first_valid != RD_LAT + 2 || last_cyc != NBINS + RD_LAT + 1 || done_cyc != NBINS + RD_LAT + 2) begin
      failures++;
      $display("FAIL timing_%s: first=%0d last=%0d done=%0d expected first=%0d last=%0d done=%0d",
               tag, first_valid, last_cyc, done_cyc, RD_LAT + 2, NBINS + RD_LAT + 1, NBINS + RD_LAT + 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stream.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ram_rdaddr, ram_wraddr, ram_data, ram_wren, stream.out_valid,
         stream.out_bin, stream.out_count, stream.out_last} !== '0) begin
      failures++;
      $display("FAIL reset_values: busy=%b done=%b rd=%0d wr=%0d data=%h wren=%b v=%b bin=%0d cnt=%h last=%b expected all 0",
               busy, done, ram_rdaddr, ram_wraddr, ram_data, ram_wren, stream.out_valid,
               stream.out_bin, stream.out_count, stream.out_last);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stream.out_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b v=%b done=%b expected 0 0 0", busy, stream.out_valid, done);
    end
  endtask

  task automatic test_sweep_noclear();
    for (int k = 0; k < NBINS; k++) load_val[k] = DW'(k * 3);
    do_load();
    run_sweep(1'b0, 0, 1'b0);
    check_timing("noclear");
  endtask

  // Starts on the cycle right after done, then re-reads the cleared RAM.
  task automatic test_back_to_back();
    run_sweep(1'b1, 0, 1'b0);
    check_timing("clear");
    run_sweep(1'b0, 0, 1'b0);
    check_timing("zeros");
    checks++;
    if (orig[5] !== '0 || orig[NBINS-1] !== '0) begin
      failures++;
      $display("FAIL cleared_readback: bin5=%h bin31=%h expected 0 0", orig[5], orig[NBINS-1]);
    end
  endtask

  task automatic test_random_ready();
    for (int k = 0; k < NBINS; k++) load_val[k] = DW'($urandom());
    load_val[7] = 32'hFFFF_FFFF;
    do_load();
    run_sweep(1'b1, 2, 1'b0);
    for (int k = 0; k < NBINS; k++) load_val[k] = DW'($urandom());
    do_load();
    run_sweep(1'b0, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < NBINS; k++) load_val[k] = DW'($urandom());
    do_load();
    run_sweep(1'b0, 1, 1'b1);
    repeat (3) tick(1'b1);
    checks++;
    if (n_done != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored: dones=%0d busy=%b expected 1 0", n_done, busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    for (int k = 0; k < NBINS; k++) load_val[k] = DW'($urandom()) | 32'h1;
    do_load();
    begin_sweep(1'b1);
    tick(1'b1);
    start = 1'b1;
    clear_en = 1'b1;
    repeat (9) begin
      tick(1'b1);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, ram_rdaddr, ram_wraddr, ram_data, ram_wren, stream.out_valid,
         stream.out_bin, stream.out_count, stream.out_last} !== '0) begin
      failures++;
      $display("FAIL midsweep_reset_values: busy=%b done=%b rd=%0d wr=%0d wren=%b v=%b bin=%0d cnt=%h expected all 0",
               busy, done, ram_rdaddr, ram_wraddr, ram_wren, stream.out_valid, stream.out_bin, stream.out_count);
    end
    @(negedge clk);
    rst = 1'b1;
    hold_prev = 1'b0;
    repeat (4) tick(1'b1);
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL midsweep_no_done: dones=%0d expected=0", n_done);
    end
    // Bins whose data returned before cycle 10 were cleared; the rest keep their values.
    bad = 0;
    for (int k = 0; k < NBINS; k++)
      if (mem[k] !== ((k < 10 - 1 - RD_LAT) ? {DW{1'b0}} : load_val[k])) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midsweep_ram: wrong_bins=%0d expected=0", bad);
    end
    run_sweep(1'b0, 0, 1'b0);
    check_timing("after_reset");
  endtask

  initial begin
    stream.out_ready = 1'b0;
    test_reset();
    test_sweep_noclear();
    test_back_to_back();
    test_random_ready();
    test_start_ignored();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
